// File: rtl/bk_cfg_sequencer.sv
// Table-driven sequencer for the BK register-config port: replays preloaded (index, value) pairs with ack supervision.
// Optional abort input and sticky err_abort flag are enabled by defining BK_CFG_ABORT_EN.
module bk_cfg_sequencer #(
  parameter int ENTRY_NUM   = 16,
  parameter int ADDR_W      = 4,
  parameter int SETUP_CYC   = 4,
  parameter int GAP_CYC     = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int ACK_BIT     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ap_start,
`ifdef BK_CFG_ABORT_EN
  input  logic              ap_abort,
  output logic              err_abort,
`endif
  output logic              ap_idle,
  output logic              ap_done,
  output logic              err_timeout,
  input  logic              tbl_wr_en,
  input  logic [ADDR_W-1:0] tbl_wr_addr,
  input  logic [31:0]       tbl_wr_index,
  input  logic [31:0]       tbl_wr_value,
  input  logic [ADDR_W:0]   entry_cnt,
  output logic [ADDR_W:0]   cur_entry,
  output logic              BkpCfg_Ready_o,
  output logic [31:0]       BkpCfg_DataIndex_o,
  output logic [31:0]       BkpCfg_DataValue_o,
  input  logic [31:0]       BK_Status_i,
  output logic [31:0]       last_status_o,
  output logic [2:0]        dbg_state_o
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_SETUP   = 3'd2;
  localparam logic [2:0] ST_ASSERT  = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;
  localparam logic [2:0] ST_GAP     = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  localparam logic [7:0]      SETUP_LAST = 8'(SETUP_CYC - 1);
  localparam logic [7:0]      GAP_LAST   = 8'(GAP_CYC - 1);
  localparam logic [31:0]     TO_LAST    = 32'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W:0] ENTRY_MAX  = (ADDR_W+1)'(ENTRY_NUM);

  logic [63:0]       tbl_q [ENTRY_NUM];
  logic [2:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [31:0]       wait_q, wait_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W:0]   cur_q, cur_d;
  logic              ready_q, ready_d;
  logic [31:0]       idx_q, idx_d;
  logic [31:0]       val_q, val_d;
  logic [31:0]       last_q, last_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              abort_err_q, abort_err_d;
  logic              start_ok;
  logic              ack;
  logic [63:0]       tbl_rd;
  logic [ADDR_W:0]   n_clamp;
  logic [ADDR_W:0]   cur_inc;

  // ap_done is registered from DONE, so the block reports busy until the pulse has been seen.
  assign ap_idle  = (state_q == ST_IDLE) && !done_q;
  assign start_ok = ap_start && ap_idle;
  assign ack      = BK_Status_i[ACK_BIT];
  assign tbl_rd   = tbl_q[ptr_q];
  assign n_clamp  = (entry_cnt > ENTRY_MAX) ? ENTRY_MAX : entry_cnt;
  assign cur_inc  = cur_q + 1'b1;

  always_ff @(posedge clk) begin
    if (tbl_wr_en && ap_idle) begin
      tbl_q[tbl_wr_addr] <= {tbl_wr_index, tbl_wr_value};
    end
  end

  // Handshake: Ready rises only after SETUP_CYC stable data cycles, falls on the cycle the
  // ack level is seen high, and the next entry waits until the ack level has dropped again.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    ptr_d       = ptr_q;
    n_d         = n_q;
    cur_d       = cur_q;
    ready_d     = ready_q;
    idx_d       = idx_q;
    val_d       = val_q;
    last_d      = last_q;
    err_d       = err_q;
    done_d      = 1'b0;
    abort_err_d = abort_err_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          n_d         = n_clamp;
          err_d       = 1'b0;
          abort_err_d = 1'b0;
          ptr_d       = '0;
          cur_d       = '0;
          state_d     = (n_clamp == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        idx_d   = tbl_rd[63:32];
        val_d   = tbl_rd[31:0];
        cnt_d   = '0;
        state_d = ST_SETUP;
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          ready_d = 1'b1;
          wait_d  = '0;
          state_d = ST_ASSERT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_ASSERT: begin
        if (ack) begin
          last_d  = BK_Status_i;
          ready_d = 1'b0;
          wait_d  = '0;
          state_d = ST_RELEASE;
        end else if (wait_q == TO_LAST) begin
          err_d   = 1'b1;
          ready_d = 1'b0;
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      ST_RELEASE: begin
        if (!ack) begin
          cur_d   = cur_inc;
          ptr_d   = ptr_q + 1'b1;
          cnt_d   = '0;
          state_d = (cur_inc == n_q) ? ST_DONE : ST_GAP;
        end else if (wait_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef BK_CFG_ABORT_EN
    // Abort overrides any ack or timeout outcome computed above for this cycle.
    if (ap_abort && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
      ready_d     = 1'b0;
      state_d     = ST_DONE;
      abort_err_d = 1'b1;
      cur_d       = cur_q;
      ptr_d       = ptr_q;
      last_d      = last_q;
      err_d       = err_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wait_q      <= '0;
      ptr_q       <= '0;
      n_q         <= '0;
      cur_q       <= '0;
      ready_q     <= 1'b0;
      idx_q       <= '0;
      val_q       <= '0;
      last_q      <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      abort_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      ptr_q       <= ptr_d;
      n_q         <= n_d;
      cur_q       <= cur_d;
      ready_q     <= ready_d;
      idx_q       <= idx_d;
      val_q       <= val_d;
      last_q      <= last_d;
      err_q       <= err_d;
      done_q      <= done_d;
      abort_err_q <= abort_err_d;
    end
  end

  assign ap_done            = done_q;
  assign err_timeout        = err_q;
  assign cur_entry          = cur_q;
  assign BkpCfg_Ready_o     = ready_q;
  assign BkpCfg_DataIndex_o = idx_q;
  assign BkpCfg_DataValue_o = val_q;
  assign last_status_o      = last_q;
  assign dbg_state_o        = state_q;
`ifdef BK_CFG_ABORT_EN
  assign err_abort = abort_err_q;
`else
  logic unused_abort;
  assign unused_abort = abort_err_q;
`endif

endmodule

// File: tb/tb_bk_cfg_sequencer.sv
// Bench for bk_cfg_sequencer: behavioural BK responder, pulse monitor and expected-pair scoreboard.
module tb_bk_cfg_sequencer;
  localparam int ENTRY_NUM = 16;
  localparam int ADDR_W    = 4;
  localparam int SETUP_CYC = 4;
  localparam int GAP_CYC   = 8;
  localparam int TO_CYC    = 100;
  localparam int BK_NORMAL = 0;
  localparam int BK_NEVER  = 1;
  localparam int BK_ALWAYS = 2;
  localparam int BK_FAIL   = 3;
  localparam logic [31:0] ALWAYS_WORD = 32'hC0DE_0001;

  logic              clk = 1'b0;
  logic              rst;
  logic              ap_start;
  logic              ap_idle, ap_done, err_timeout;
  logic              tbl_wr_en;
  logic [ADDR_W-1:0] tbl_wr_addr;
  logic [31:0]       tbl_wr_index, tbl_wr_value;
  logic [ADDR_W:0]   entry_cnt;
  logic [ADDR_W:0]   cur_entry;
  logic              BkpCfg_Ready_o;
  logic [31:0]       BkpCfg_DataIndex_o, BkpCfg_DataValue_o;
  logic [31:0]       BK_Status_i;
  logic [31:0]       last_status_o;
  logic [2:0]        dbg_state_o;
`ifdef BK_CFG_ABORT_EN
  logic              ap_abort;
  logic              err_abort;
`endif

  bk_cfg_sequencer #(
    .ENTRY_NUM(ENTRY_NUM), .ADDR_W(ADDR_W), .SETUP_CYC(SETUP_CYC),
    .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TO_CYC), .ACK_BIT(0)
  ) dut (
    .clk(clk), .rst(rst), .ap_start(ap_start),
`ifdef BK_CFG_ABORT_EN
    .ap_abort(ap_abort), .err_abort(err_abort),
`endif
    .ap_idle(ap_idle), .ap_done(ap_done), .err_timeout(err_timeout),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr),
    .tbl_wr_index(tbl_wr_index), .tbl_wr_value(tbl_wr_value),
    .entry_cnt(entry_cnt), .cur_entry(cur_entry),
    .BkpCfg_Ready_o(BkpCfg_Ready_o), .BkpCfg_DataIndex_o(BkpCfg_DataIndex_o),
    .BkpCfg_DataValue_o(BkpCfg_DataValue_o), .BK_Status_i(BK_Status_i),
    .last_status_o(last_status_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model / scoreboard state ----------------
  logic [63:0] tbl_m [ENTRY_NUM];
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  int vectors = 0;
  int miscompares = 0;

  // BK configuration, written only by the stimulus block
  int bk_mode = BK_NORMAL;
  int ack_dly = 2;
  int rel_dly = 1;
  int fail_pulse = 0;
  logic clr_mon = 1'b0;

  // monitor / responder state, written only by the negedge block
  int pulse_cnt, pulse_w, done_cnt, done_cyc, idle_low, setup_bad, stable_cnt, bk_cnt;
  int first_rise_cyc;
  logic rdy_prev;
  logic [63:0] prev_data;
  logic [31:0] bk_status = 32'h0;
  logic [31:0] last_ack_status = 32'h0;
  assign BK_Status_i = bk_status;

  always @(negedge clk) begin
    logic [63:0] cur_data;
    logic hold;
    cur_data = {BkpCfg_DataIndex_o, BkpCfg_DataValue_o};
    if (clr_mon) begin
      obs_q.delete();
      pulse_cnt = 0; pulse_w = 0; done_cnt = 0; done_cyc = 0; idle_low = 0;
      setup_bad = 0; stable_cnt = 0; bk_cnt = 0; first_rise_cyc = 0;
      rdy_prev = BkpCfg_Ready_o;
      prev_data = cur_data;
      bk_status = (bk_mode == BK_ALWAYS) ? ALWAYS_WORD : 32'h0;
      last_ack_status = (bk_mode == BK_ALWAYS) ? ALWAYS_WORD : last_ack_status;
    end else begin
      if (cur_data != prev_data) stable_cnt = 0; else stable_cnt++;
      prev_data = cur_data;
      if (BkpCfg_Ready_o && !rdy_prev) begin
        obs_q.push_back(cur_data);
        if (pulse_cnt == 0) first_rise_cyc = cyc;
        if (stable_cnt < SETUP_CYC) setup_bad++;
        pulse_cnt++;
        pulse_w = 0;
      end
      if (BkpCfg_Ready_o) pulse_w++;
      rdy_prev = BkpCfg_Ready_o;
      if (ap_done) begin done_cnt++; done_cyc = cyc; end
      if (!ap_idle) idle_low++;
      // BK responder: raise ack ack_dly samples into a Ready pulse, drop it rel_dly samples after Ready falls
      hold = (bk_mode == BK_NEVER) || (bk_mode == BK_FAIL && pulse_cnt == fail_pulse + 1);
      if (bk_mode != BK_ALWAYS) begin
        if (BkpCfg_Ready_o && !bk_status[0]) begin
          if (!hold) begin
            if (bk_cnt + 1 >= ack_dly) begin
              bk_status = $urandom() | 32'h1;
              last_ack_status = bk_status;
              bk_cnt = 0;
            end else bk_cnt++;
          end
        end else if (!BkpCfg_Ready_o && bk_status[0]) begin
          if (bk_cnt + 1 >= rel_dly) begin
            bk_status = $urandom() & ~32'h1;
            bk_cnt = 0;
          end else bk_cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    clr_mon = 1'b1;
    tick();
    clr_mon = 1'b0;
  endtask

  task automatic write_tbl(input int addr, input logic [31:0] idx, input logic [31:0] val);
    tbl_wr_en = 1'b1; tbl_wr_addr = addr[ADDR_W-1:0]; tbl_wr_index = idx; tbl_wr_value = val;
    tick();
    tbl_wr_en = 1'b0;
    tbl_m[addr] = {idx, val};
  endtask

  task automatic load_exp(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(tbl_m[i % ENTRY_NUM]);
  endtask

  task automatic start_run(input int cnt, output int start_cyc);
    entry_cnt = cnt[ADDR_W:0];
    ap_start = 1'b1;
    start_cyc = cyc;
    tick();
    ap_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin tick(); n++; end
    check({tag, "/done_seen"}, 64'(done_cnt != 0), 64'd1);
    repeat (3) tick();
    check({tag, "/done_once"}, 64'(done_cnt), 64'd1);
    check({tag, "/idle_after"}, 64'(ap_idle), 64'd1);
  endtask

  task automatic check_pairs(input string tag);
    check({tag, "/npulse"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, "/pair"}, obs_q[i], exp_q[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int sc, n, cnt;
    rst = 1'b1; ap_start = 1'b0; tbl_wr_en = 1'b0; tbl_wr_addr = '0;
    tbl_wr_index = '0; tbl_wr_value = '0; entry_cnt = '0;
`ifdef BK_CFG_ABORT_EN
    ap_abort = 1'b0;
`endif
    for (int i = 0; i < ENTRY_NUM; i++) tbl_m[i] = 64'h0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst/idle", 64'(ap_idle), 64'd1);
    check("rst/done", 64'(ap_done), 64'd0);
    check("rst/err", 64'(err_timeout), 64'd0);
    check("rst/cur", 64'(cur_entry), 64'd0);
    check("rst/ready", 64'(BkpCfg_Ready_o), 64'd0);
    check("rst/data", {BkpCfg_DataIndex_o, BkpCfg_DataValue_o}, 64'h0);
    check("rst/last", 64'(last_status_o), 64'd0);

    // three-entry directed replay
    write_tbl(0, 32'h10, 32'hA5);
    write_tbl(1, 32'h11, 32'h5A);
    write_tbl(2, 32'h12, 32'hFF);
    bk_mode = BK_NORMAL; ack_dly = 2; rel_dly = 1;
    clear_mon();
    load_exp(3);
    start_run(3, sc);
    wait_done("basic", 400);
    check_pairs("basic");
    check("basic/latency", 64'(first_rise_cyc - sc), 64'(2 + SETUP_CYC));
    check("basic/setup", 64'(setup_bad), 64'd0);
    check("basic/cur", 64'(cur_entry), 64'd3);
    check("basic/err", 64'(err_timeout), 64'd0);
    check("basic/last", 64'(last_status_o), 64'(last_ack_status));
    check("basic/hold", {BkpCfg_DataIndex_o, BkpCfg_DataValue_o}, tbl_m[2]);

    // zero entries
    clear_mon();
    exp_q.delete();
    start_run(0, sc);
    wait_done("zero", 20);
    check_pairs("zero");
    check("zero/done_lat", 64'(done_cyc - sc), 64'd2);
    check("zero/idle_low", 64'(idle_low), 64'd2);
    check("zero/cur", 64'(cur_entry), 64'd0);

    // entry 1 never acked
    bk_mode = BK_FAIL; fail_pulse = 1;
    clear_mon();
    load_exp(2);
    start_run(3, sc);
    wait_done("tmo", 600);
    check_pairs("tmo");
    check("tmo/width", 64'(pulse_w), 64'(TO_CYC));
    check("tmo/ready_low", 64'(BkpCfg_Ready_o), 64'd0);
    check("tmo/err", 64'(err_timeout), 64'd1);
    check("tmo/cur", 64'(cur_entry), 64'd1);
    check("tmo/last", 64'(last_status_o), 64'(last_ack_status));

    // good BK afterwards clears the sticky error
    bk_mode = BK_NORMAL;
    clear_mon();
    load_exp(3);
    start_run(3, sc);
    check("rerun/err_clr", 64'(err_timeout), 64'd0);
    wait_done("rerun", 400);
    check_pairs("rerun");
    check("rerun/err", 64'(err_timeout), 64'd0);
    check("rerun/cur", 64'(cur_entry), 64'd3);

    // ack stuck high: immediate accept then release timeout
    bk_mode = BK_ALWAYS;
    clear_mon();
    load_exp(1);
    start_run(2, sc);
    wait_done("stuck", 600);
    check_pairs("stuck");
    check("stuck/width", 64'(pulse_w), 64'd1);
    check("stuck/err", 64'(err_timeout), 64'd1);
    check("stuck/cur", 64'(cur_entry), 64'd0);
    check("stuck/last", 64'(last_status_o), 64'(ALWAYS_WORD));

    // write in the start cycle is used; writes and starts while busy are ignored
    bk_mode = BK_NORMAL; ack_dly = 3; rel_dly = 2;
    clear_mon();
    tbl_wr_en = 1'b1; tbl_wr_addr = '0; tbl_wr_index = 32'h0000_0777; tbl_wr_value = 32'hBEEF_0000;
    tbl_m[0] = {32'h0000_0777, 32'hBEEF_0000};
    entry_cnt = 5'd3; ap_start = 1'b1;
    tick();
    tbl_wr_en = 1'b0; ap_start = 1'b0;
    load_exp(3);
    repeat (10) tick();
    tbl_wr_en = 1'b1; tbl_wr_addr = 4'd1; tbl_wr_index = 32'hDEAD_DEAD; tbl_wr_value = 32'h1234_5678;
    ap_start = 1'b1; entry_cnt = 5'd1;
    tick();
    tbl_wr_en = 1'b0; ap_start = 1'b0;
    wait_done("busy", 400);
    check_pairs("busy");
    check("busy/cur", 64'(cur_entry), 64'd3);

    // randomized tables, counts and BK timing
    for (int it = 0; it < 6; it++) begin
      for (int a = 0; a < ENTRY_NUM; a++) write_tbl(a, $urandom(), $urandom());
      cnt = $urandom_range(0, 31);
      n = (cnt > ENTRY_NUM) ? ENTRY_NUM : cnt;
      ack_dly = $urandom_range(1, 4);
      rel_dly = $urandom_range(1, 6);
      clear_mon();
      load_exp(n);
      start_run(cnt, sc);
      wait_done("rand", 1500);
      check_pairs("rand");
      check("rand/cur", 64'(cur_entry), 64'(n));
      check("rand/err", 64'(err_timeout), 64'd0);
      check("rand/setup", 64'(setup_bad), 64'd0);
      if (n > 0) check("rand/last", 64'(last_status_o), 64'(last_ack_status));
    end

    // reset while Ready is high
    ack_dly = 6; rel_dly = 1;
    clear_mon();
    start_run(3, sc);
    n = 0;
    while (!BkpCfg_Ready_o && n < 50) begin tick(); n++; end
    check("rstmid/ready_seen", 64'(BkpCfg_Ready_o), 64'd1);
    rst = 1'b1;
    tick();
    check("rstmid/ready", 64'(BkpCfg_Ready_o), 64'd0);
    check("rstmid/idle", 64'(ap_idle), 64'd1);
    check("rstmid/cur", 64'(cur_entry), 64'd0);
    rst = 1'b0;
    tick();

`ifdef BK_CFG_ABORT_EN
    // abort during SETUP
    ack_dly = 2;
    clear_mon();
    exp_q.delete();
    start_run(2, sc);
    tick();
    ap_abort = 1'b1;
    tick();
    ap_abort = 1'b0;
    wait_done("abort", 20);
    check_pairs("abort");
    check("abort/flag", 64'(err_abort), 64'd1);
    check("abort/err", 64'(err_timeout), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
